wh_link_util_monitor: RTL

Parametrised, synthesizable wormhole-link utilization monitor for the pod-ruche array. Per link it counts idle, stall and transfer cycles and tracks the longest stall run, with saturating counters of configurable width. A snapshot command atomically copies all live counters into shadow registers, optionally clearing them. A registered read port lets the host or a CSR block fetch any shadow counter without the simulation-only file I/O of the previous profiler.

---
 rtl/wh_link_util_pkg.sv | 40 ++++
 rtl/wh_link_util_lane.sv | 95 +++++++++
 rtl/wh_link_util_monitor.sv | 108 ++++++++++
 3 files changed

// File: rtl/wh_link_util_pkg.sv
// -----------------------------------------------------------------------------
// wh_link_util_pkg
// Shared definitions for the wormhole-link utilization monitor.
//   - wh_util_sel_e   : counter select used by the read port
//   - WH_UTIL_CTR_S() : per-link counter struct {idle, stall, xfer, max_stall},
//                       built by macro so each module can size it with its own
//                       counter_width_p
//   - safe_clog2()    : index width that never collapses to zero bits
// -----------------------------------------------------------------------------
`ifndef WH_LINK_UTIL_PKG_SV
`define WH_LINK_UTIL_PKG_SV

// Field order puts idle in the MSBs; readers access fields by name only.
`define WH_UTIL_CTR_S(width) \
    struct packed { \
        logic [(width)-1:0] idle; \
        logic [(width)-1:0] stall; \
        logic [(width)-1:0] xfer; \
        logic [(width)-1:0] max_stall; \
    }

package wh_link_util_pkg;

    typedef enum logic [1:0] {
        wh_util_idle      = 2'd0,
        wh_util_stall     = 2'd1,
        wh_util_xfer      = 2'd2,
        wh_util_max_stall = 2'd3
    } wh_util_sel_e;

    localparam int snapshot_count_width_lp = 16;

    // A single link still needs a one-bit index port.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`endif

// File: rtl/wh_link_util_lane.sv
// -----------------------------------------------------------------------------
// wh_link_util_lane
// Per-link cycle classifier with saturating idle/stall/xfer counters, a stall
// run tracker with its longest-run record, and the shadow copy taken on
// snapshot.
// Ports:
//   clk_i, reset_i : clock, asynchronous active-high reset
//   en             : count enable; low freezes counters and run tracking
//   v, ready       : link handshake (sender valid, receiver ready)
//   snapshot       : copy live counters to the shadow struct this cycle
//   shadow         : registered shadow counters
// -----------------------------------------------------------------------------
module wh_link_util_lane
    import wh_link_util_pkg::*;
#(
    parameter int counter_width_p     = 32,
    parameter bit clear_on_snapshot_p = 1'b1
)(
    input  logic clk_i,
    input  logic reset_i,
    input  logic en,
    input  logic v,
    input  logic ready,
    input  logic snapshot,
    output `WH_UTIL_CTR_S(counter_width_p) shadow
);

    typedef logic [counter_width_p-1:0] ctr_t;
    typedef `WH_UTIL_CTR_S(counter_width_p) wh_util_ctr_s;

    localparam ctr_t ctr_max_lp = '1;

    // live_r.max_stall is the running longest-stall record.
    wh_util_ctr_s live_r, live_n;
    wh_util_ctr_s shadow_r;
    ctr_t         run_r, run_n;

    logic idle_ev, stall_ev, xfer_ev;

    assign idle_ev  = en & ~v;
    assign stall_ev = en &  v & ~ready;
    assign xfer_ev  = en &  v &  ready;

    function automatic ctr_t sat_inc(input ctr_t value, input logic inc);
        return (inc && (value != ctr_max_lp)) ? value + ctr_t'(1) : value;
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves a latch.
        run_n  = run_r;
        live_n = live_r;

        // run_n is the run length including this cycle's stall.
        if (stall_ev) begin
            run_n = sat_inc(run_r, 1'b1);
        end else if (en) begin
            run_n = '0;
        end

        if (snapshot && clear_on_snapshot_p) begin
            // Restart from this cycle's event so nothing falls between the shadow
            // and the new live window; the run itself keeps going.
            live_n.idle      = ctr_t'(idle_ev);
            live_n.stall     = ctr_t'(stall_ev);
            live_n.xfer      = ctr_t'(xfer_ev);
            live_n.max_stall = stall_ev ? run_n : '0;
        end else begin
            live_n.idle  = sat_inc(live_r.idle,  idle_ev);
            live_n.stall = sat_inc(live_r.stall, stall_ev);
            live_n.xfer  = sat_inc(live_r.xfer,  xfer_ev);
            if (stall_ev && (run_n > live_r.max_stall)) begin
                live_n.max_stall = run_n;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            live_r   <= '0;
            run_r    <= '0;
            // NOTE: the shadow bank is plain flops, not a RAM, so it is reset too; reads must return 0 after reset.
            shadow_r <= '0;
        end else begin
            live_r <= live_n;
            run_r  <= run_n;
            if (snapshot) begin
                shadow_r <= live_r;
            end
        end
    end

    assign shadow = shadow_r;

endmodule

// File: rtl/wh_link_util_monitor.sv
// -----------------------------------------------------------------------------
// wh_link_util_monitor
// Utilization monitor for num_links_p unidirectional wormhole links. Each lane
// classifies cycles and keeps saturating counters; a snapshot pulse copies all
// of them into shadow registers that a registered read port serves.
// Ports:
//   clk_i, reset_i     : clock, asynchronous active-high reset
//   en_i               : count enable
//   link_v_i           : per-link flit valid
//   link_ready_i       : per-link receiver ready
//   snapshot_v_i       : one-cycle snapshot pulse
//   rd_v_i             : read request (accepted every cycle)
//   rd_link_i          : link index; out-of-range indices read 0
//   rd_sel_i           : 0 idle, 1 stall, 2 xfer, 3 max stall run
//   rd_v_o             : read data valid, one cycle after rd_v_i
//   rd_data_o          : read data, held while rd_v_o is low
//   snapshot_count_o   : snapshots taken, wrapping
// -----------------------------------------------------------------------------
module wh_link_util_monitor
    import wh_link_util_pkg::*;
#(
    parameter int  num_links_p         = 8,
    parameter int  counter_width_p     = 32,
    parameter bit  clear_on_snapshot_p = 1'b1,
    localparam int lg_links_lp         = safe_clog2(num_links_p)
)(
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic                                en_i,
    input  logic [num_links_p-1:0]              link_v_i,
    input  logic [num_links_p-1:0]              link_ready_i,
    input  logic                                snapshot_v_i,
    input  logic                                rd_v_i,
    input  logic [lg_links_lp-1:0]              rd_link_i,
    input  logic [1:0]                          rd_sel_i,
    output logic                                rd_v_o,
    output logic [counter_width_p-1:0]          rd_data_o,
    output logic [snapshot_count_width_lp-1:0]  snapshot_count_o
);

    typedef `WH_UTIL_CTR_S(counter_width_p) wh_util_ctr_s;

    wh_util_ctr_s                      shadow [num_links_p];
    wh_util_ctr_s                      rd_shadow;
    logic [counter_width_p-1:0]        rd_data_n;
    logic [snapshot_count_width_lp-1:0] snapshot_count_r;

    for (genvar i = 0; i < num_links_p; i++) begin : g_lane
        wh_link_util_lane #(
            .counter_width_p     (counter_width_p),
            .clear_on_snapshot_p (clear_on_snapshot_p)
        ) u_lane (
            .clk_i    (clk_i),
            .reset_i  (reset_i),
            .en       (en_i),
            .v        (link_v_i[i]),
            .ready    (link_ready_i[i]),
            .snapshot (snapshot_v_i),
            .shadow   (shadow[i])
        );
    end

    // Compare-based link select: an index with no matching lane leaves zero,
    // which covers rd_link_i >= num_links_p without indexing past the array.
    always_comb begin
        rd_shadow = '0;
        for (int i = 0; i < num_links_p; i++) begin
            if (rd_link_i == lg_links_lp'(i)) begin
                rd_shadow = shadow[i];
            end
        end
    end

    always_comb begin
        rd_data_n = '0;
        case (wh_util_sel_e'(rd_sel_i))
            wh_util_idle:      rd_data_n = rd_shadow.idle;
            wh_util_stall:     rd_data_n = rd_shadow.stall;
            wh_util_xfer:      rd_data_n = rd_shadow.xfer;
            wh_util_max_stall: rd_data_n = rd_shadow.max_stall;
        endcase
    end

    // The mux reads the shadow before this edge updates it, so a read that
    // coincides with a snapshot returns the previous snapshot's value.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_v_o    <= 1'b0;
            rd_data_o <= '0;
        end else begin
            rd_v_o <= rd_v_i;
            if (rd_v_i) begin
                rd_data_o <= rd_data_n;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            snapshot_count_r <= '0;
        end else if (snapshot_v_i) begin
            snapshot_count_r <= snapshot_count_r + 1'b1;
        end
    end

    assign snapshot_count_o = snapshot_count_r;

endmodule
